plc_updown_counter: RTL and testbench

- Parametrised successor to the fixed-width PLC counter timer/counter block.
- Implements IEC-style CTU, CTD and CTUD counters with edge-detected count inputs, synchronous clear/load, preset compare, and saturate-or-wrap arithmetic.
- Sits in the timer/counter peripheral bank. The processor drives preset, mode and count lines, and reads acc and the status bits.

---
 rtl/plc_updown_counter.sv | 117 +++++++++++
 tb/tb_plc_updown_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/plc_updown_counter.sv
// IEC-style CTU/CTD/CTUD counter: edge-detected count lines, clear/load that
// latch the mode, preset compare for dn, and saturating or wrapping arithmetic.
module plc_updown_counter #(
    parameter int ACC_W = 16,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       cnt_type,
    input  logic             cu_in,
    input  logic             cd_in,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] preset,
    output logic [ACC_W-1:0] acc,
    output logic             dn,
    output logic             cu,
    output logic             cd,
    output logic             ov,
    output logic             un
);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_CTU  = 2'b01;
    localparam logic [1:0] MODE_CTD  = 2'b10;
    localparam logic [1:0] MODE_CTUD = 2'b11;

    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    logic [1:0]       mode_r;
    logic             cu_prev_r;
    logic             cd_prev_r;
    logic [1:0]       mode_next_s;
    logic             up_ev_s;
    logic             dn_ev_s;
    logic             do_up_s;
    logic             do_dn_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             ov_next_s;
    logic             un_next_s;
    logic             dn_next_s;

    // Event qualification and next-state arithmetic; clr beats load beats counting.
    always_comb begin
        mode_next_s = (clr || load) ? cnt_type : mode_r;
        up_ev_s     = cu_in & ~cu_prev_r & en;
        dn_ev_s     = cd_in & ~cd_prev_r & en;
        do_up_s     = up_ev_s && ((mode_r == MODE_CTU) || ((mode_r == MODE_CTUD) && !dn_ev_s));
        do_dn_s     = dn_ev_s && ((mode_r == MODE_CTD) || ((mode_r == MODE_CTUD) && !up_ev_s));
        acc_next_s  = acc;
        ov_next_s   = ov;
        un_next_s   = un;
        if (clr) begin
            acc_next_s = ACC_ZERO;
            ov_next_s  = 1'b0;
            un_next_s  = 1'b0;
        end else if (load) begin
            acc_next_s = preset;
        end else if (do_up_s) begin
            if (acc == ACC_MAX) begin
                ov_next_s  = 1'b1;
                acc_next_s = WRAP ? ACC_ZERO : acc;
            end else begin
                acc_next_s = acc + ACC_ONE;
            end
        end else if (do_dn_s) begin
            if (acc == ACC_ZERO) begin
                un_next_s  = 1'b1;
                acc_next_s = WRAP ? ACC_MAX : acc;
            end else begin
                acc_next_s = acc - ACC_ONE;
            end
        end else begin
            acc_next_s = acc;
        end
    end

    // Done flag evaluated against the value acc will hold, so the two stay coherent.
    always_comb begin
        dn_next_s = dn;
        case (mode_next_s)
            MODE_CTU, MODE_CTUD: dn_next_s = (acc_next_s >= preset);
            MODE_CTD:            dn_next_s = (acc_next_s == ACC_ZERO);
            MODE_IDLE:           dn_next_s = dn;
            default:             dn_next_s = dn;
        endcase
    end

    // State registers; edge history tracks the lines even while en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r    <= MODE_IDLE;
            cu_prev_r <= 1'b0;
            cd_prev_r <= 1'b0;
            acc       <= ACC_ZERO;
            dn        <= 1'b0;
            cu        <= 1'b0;
            cd        <= 1'b0;
            ov        <= 1'b0;
            un        <= 1'b0;
        end else begin
            mode_r    <= mode_next_s;
            cu_prev_r <= cu_in;
            cd_prev_r <= cd_in;
            acc       <= acc_next_s;
            dn        <= dn_next_s;
            cu        <= cu_in & en;
            cd        <= cd_in & en;
            ov        <= ov_next_s;
            un        <= un_next_s;
        end
    end

endmodule

// File: tb/tb_plc_updown_counter.sv
// Directed plus randomized bench for plc_updown_counter; three builds (16-bit
// saturating, 4-bit wrapping, 4-bit saturating) share stimulus and are compared to a model.
module tb_plc_updown_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  cnt_type = 2'b00;
    logic        cu_in = 1'b0;
    logic        cd_in = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;

    logic [15:0] acc_a;
    logic [3:0]  acc_b, acc_c;
    logic        dn_a, cu_a, cd_a, ov_a, un_a;
    logic        dn_b, cu_b, cd_b, ov_b, un_b;
    logic        dn_c, cu_c, cd_c, ov_c, un_c;

    int total = 0;
    int bad = 0;

    // model state: index 0 = 16-bit sat, 1 = 4-bit wrap, 2 = 4-bit sat
    int m_acc[3];
    bit m_dn[3], m_ov[3], m_un[3];
    bit m_cu, m_cd, m_cup, m_cdp;
    int m_mode;
    int maxv[3] = '{65535, 15, 15};
    bit wrapv[3] = '{1'b0, 1'b1, 1'b0};

    plc_updown_counter #(.ACC_W(16), .WRAP(1'b0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .cnt_type(cnt_type), .cu_in(cu_in), .cd_in(cd_in),
        .clr(clr), .load(load), .preset(preset), .acc(acc_a), .dn(dn_a), .cu(cu_a), .cd(cd_a),
        .ov(ov_a), .un(un_a));
    plc_updown_counter #(.ACC_W(4), .WRAP(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .cnt_type(cnt_type), .cu_in(cu_in), .cd_in(cd_in),
        .clr(clr), .load(load), .preset(preset[3:0]), .acc(acc_b), .dn(dn_b), .cu(cu_b), .cd(cd_b),
        .ov(ov_b), .un(un_b));
    plc_updown_counter #(.ACC_W(4), .WRAP(1'b0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .cnt_type(cnt_type), .cu_in(cu_in), .cd_in(cd_in),
        .clr(clr), .load(load), .preset(preset[3:0]), .acc(acc_c), .dn(dn_c), .cu(cu_c), .cd(cd_c),
        .ov(ov_c), .un(un_c));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_dn[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
        end
        m_cu = 1'b0; m_cd = 1'b0; m_cup = 1'b0; m_cdp = 1'b0; m_mode = 0;
    endtask

    // Applies the counter rules to the inputs present just before the edge.
    task automatic model_step();
        bit up, dnv, inc, dec;
        int nm, pr;
        up  = cu_in && !m_cup && en;
        dnv = cd_in && !m_cdp && en;
        nm  = (clr || load) ? int'(cnt_type) : m_mode;
        inc = up && (m_mode == 1 || (m_mode == 3 && !dnv));
        dec = dnv && (m_mode == 2 || (m_mode == 3 && !up));
        for (int i = 0; i < 3; i++) begin
            pr = int'(preset) % (maxv[i] + 1);
            if (clr) begin
                m_acc[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
            end else if (load) begin
                m_acc[i] = pr;
            end else if (inc) begin
                if (m_acc[i] == maxv[i]) begin
                    m_ov[i] = 1'b1;
                    if (wrapv[i]) m_acc[i] = 0;
                end else m_acc[i] = m_acc[i] + 1;
            end else if (dec) begin
                if (m_acc[i] == 0) begin
                    m_un[i] = 1'b1;
                    if (wrapv[i]) m_acc[i] = maxv[i];
                end else m_acc[i] = m_acc[i] - 1;
            end
            if (nm == 1 || nm == 3) m_dn[i] = (m_acc[i] >= pr);
            else if (nm == 2) m_dn[i] = (m_acc[i] == 0);
        end
        m_cu = cu_in && en; m_cd = cd_in && en;
        m_cup = cu_in; m_cdp = cd_in; m_mode = nm;
    endtask

    task automatic check_all();
        chk("acc_a", 32'(acc_a), m_acc[0]); chk("dn_a", 32'(dn_a), 32'(m_dn[0]));
        chk("ov_a", 32'(ov_a), 32'(m_ov[0])); chk("un_a", 32'(un_a), 32'(m_un[0]));
        chk("cu_a", 32'(cu_a), 32'(m_cu)); chk("cd_a", 32'(cd_a), 32'(m_cd));
        chk("acc_b", 32'(acc_b), m_acc[1]); chk("dn_b", 32'(dn_b), 32'(m_dn[1]));
        chk("ov_b", 32'(ov_b), 32'(m_ov[1])); chk("un_b", 32'(un_b), 32'(m_un[1]));
        chk("cu_b", 32'(cu_b), 32'(m_cu)); chk("cd_b", 32'(cd_b), 32'(m_cd));
        chk("acc_c", 32'(acc_c), m_acc[2]); chk("dn_c", 32'(dn_c), 32'(m_dn[2]));
        chk("ov_c", 32'(ov_c), 32'(m_ov[2])); chk("un_c", 32'(un_c), 32'(m_un[2]));
        chk("cu_c", 32'(cu_c), 32'(m_cu)); chk("cd_c", 32'(cd_c), 32'(m_cd));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ctl(input bit c, input bit l, input logic [1:0] t, input logic [15:0] p);
        clr = c; load = l; cnt_type = t; preset = p;
        cycle();
        clr = 1'b0; load = 1'b0;
    endtask

    task automatic pulse_cu();
        cu_in = 1'b1; cycle(); cu_in = 1'b0; cycle();
    endtask

    task automatic pulse_cd();
        cd_in = 1'b1; cycle(); cd_in = 1'b0; cycle();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_acc_b", 32'(acc_b), 32'd0);
        chk("rst_ov_b", 32'(ov_b), 32'd0);
        chk("rst_dn_a", 32'(dn_a), 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        int pv;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all();
        #1 reset = 1'b0;

        // CTU to preset 3
        en = 1'b1;
        ctl(1'b1, 1'b0, 2'b01, 16'd3);
        for (int k = 0; k < 3; k++) pulse_cu();
        chk("ctu_acc3", 32'(acc_a), 32'd3);
        chk("ctu_dn", 32'(dn_a), 32'd1);

        // CTD from 2 with underflow, then clear
        ctl(1'b0, 1'b1, 2'b10, 16'd2);
        for (int k = 0; k < 3; k++) pulse_cd();
        chk("ctd_acc0", 32'(acc_a), 32'd0);
        chk("ctd_un", 32'(un_a), 32'd1);
        ctl(1'b1, 1'b0, 2'b10, 16'd2);
        chk("ctd_clr_un", 32'(un_a), 32'd0);

        // increment at all-ones
        ctl(1'b0, 1'b1, 2'b01, 16'd15);
        pulse_cu();
        chk("wrap_acc", 32'(acc_b), 32'd0);
        chk("wrap_ov", 32'(ov_b), 32'd1);
        chk("wrap_dn", 32'(dn_b), 32'd0);
        chk("sat_acc", 32'(acc_c), 32'd15);
        chk("sat_ov", 32'(ov_c), 32'd1);

        // acc=9 dn=1 ov=1, then async reset and idle behaviour
        ctl(1'b0, 1'b1, 2'b01, 16'd9);
        chk("pre_rst_acc", 32'(acc_b), 32'd9);
        async_reset();
        pulse_cu(); pulse_cu();
        chk("idle_acc", 32'(acc_a), 32'd0);
        ctl(1'b1, 1'b0, 2'b01, 16'd3);
        pulse_cu();
        chk("after_clr_acc", 32'(acc_a), 32'd1);

        // CTUD: simultaneous events, held line, clr with rising line
        ctl(1'b0, 1'b1, 2'b11, 16'd5);
        cu_in = 1'b1; cd_in = 1'b1; cycle();
        chk("both_acc", 32'(acc_a), 32'd5);
        cu_in = 1'b0; cd_in = 1'b0; cycle();
        cu_in = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        chk("held_acc", 32'(acc_a), 32'd6);
        cu_in = 1'b0; cycle();
        cu_in = 1'b1; clr = 1'b1; cnt_type = 2'b11; cycle();
        chk("clr_wins", 32'(acc_a), 32'd0);
        clr = 1'b0; cu_in = 1'b0; cycle();

        // enable gating
        en = 1'b0;
        for (int k = 0; k < 3; k++) pulse_cu();
        cu_in = 1'b1; cycle();
        en = 1'b1; cycle(); cycle();
        chk("en_gate_acc", 32'(acc_a), 32'd0);
        cu_in = 1'b0; cycle();

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            en    = ($urandom_range(0, 4) != 0);
            cu_in = $urandom_range(0, 1) == 1;
            cd_in = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 24) == 0);
            cnt_type = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pv = 65535 - $urandom_range(0, 3);
            else pv = $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) preset = 16'(pv);
            if ($urandom_range(0, 149) == 0) async_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
